// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the datapath bus blocks: select-mode encodings and the
// default bus width.
package cpu_bus_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int unsigned BUS_WIDTH = 10;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping mod N.
// Purely combinational.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int unsigned SELW = $clog2(N);

    logic [SELW-1:0] cand;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // The modulo keeps the candidate in range even when N is not a power of two.
            cand = SELW'((32'(ptr) + i) % N);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_select_arb.sv
// N:1 source-bus selector with a one-entry registered output. Sources are chosen
// either by an explicit index or by a round-robin arbiter.
module bus_select_arb
    import cpu_bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH,
    parameter int unsigned N     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_src
);

    localparam int unsigned SELW = $clog2(N);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  src_q, src_d;
    logic             valid_q, valid_d;

    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic             dir_any;
    logic [SELW-1:0]  g_idx;
    logic             g_any;
    logic             load;
    logic             xfer;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        dir_any = 1'b0;
        // sel may exceed N-1 when N is not a power of two; such a select grants nothing.
        if (32'(sel) < N) begin
            dir_any = in_valid[sel];
        end
        g_idx = (mode == MODE_RR) ? rr_idx : sel;
        g_any = (mode == MODE_RR) ? rr_any : dir_any;
        load  = ~valid_q | out_ready;
        xfer  = load & g_any & ~reset;
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[g_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = in_data[32'(g_idx) * WIDTH +: WIDTH];
            src_d   = g_idx;
            valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (g_idx == SELW'(N - 1)) ? '0 : g_idx + SELW'(1);
            end
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_bus_select_arb.sv
// Directed bench for bus_select_arb: a vector table on an N=4 instance plus
// hand-written sequences for reset, N=3 out-of-range select and mid-transfer reset.
module tb_bus_select_arb;
    import cpu_bus_pkg::*;

    logic        clock;
    logic        reset;

    logic [39:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [9:0]  out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic [1:0]  out_src4;

    logic [29:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [9:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_src3;

    int checks;
    int errors;

    bus_select_arb #(.WIDTH(10), .N(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .mode      (mode4),
        .sel       (sel4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_src   (out_src4)
    );

    bus_select_arb #(.WIDTH(10), .N(3)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_src   (out_src3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [9:0] exp_od;
        logic [1:0] exp_src;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Source i data, source 3 in the top slice.
        in_data4 = {10'h2aa, 10'h155, 10'h122, 10'h011};
        in_data3 = {10'h0f0, 10'h0e1, 10'h0d2};

        //              mode         sel    valid    ordy  rdy      ov    od       src
        vecs[0]  = '{MODE_DIRECT, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2};
        vecs[1]  = '{MODE_DIRECT, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 10'h155, 2'd2};
        vecs[2]  = '{MODE_DIRECT, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 10'h155, 2'd2};
        vecs[3]  = '{MODE_DIRECT, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 10'h155, 2'd2};
        vecs[4]  = '{MODE_DIRECT, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 10'h122, 2'd1};
        vecs[5]  = '{MODE_DIRECT, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'h122, 2'd1};
        vecs[6]  = '{MODE_DIRECT, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 10'h122, 2'd1};
        vecs[7]  = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 10'h011, 2'd0};
        vecs[8]  = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 10'h122, 2'd1};
        vecs[9]  = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2};
        vecs[10] = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 10'h2aa, 2'd3};
        vecs[11] = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 10'h011, 2'd0};
        vecs[12] = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 10'h122, 2'd1};
        vecs[13] = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2};
        vecs[14] = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 10'h2aa, 2'd3};
        vecs[15] = '{MODE_RR,     2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2};
        vecs[16] = '{MODE_RR,     2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 10'h011, 2'd0};
        vecs[17] = '{MODE_RR,     2'd0, 4'b0011, 1'b1, 4'b0010, 1'b1, 10'h122, 2'd1};
        vecs[18] = '{MODE_DIRECT, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 10'h2aa, 2'd3};
        vecs[19] = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 10'h155, 2'd2};
        vecs[20] = '{MODE_RR,     2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'h155, 2'd2};
        vecs[21] = '{MODE_RR,     2'd0, 4'b1001, 1'b0, 4'b1000, 1'b1, 10'h2aa, 2'd3};
        vecs[22] = '{MODE_RR,     2'd0, 4'b1001, 1'b0, 4'b0000, 1'b1, 10'h2aa, 2'd3};

        // Reset with every source requesting: nothing may be accepted.
        reset      = 1'b1;
        mode4      = MODE_DIRECT;
        sel4       = 2'd0;
        in_valid4  = 4'b1111;
        out_ready4 = 1'b1;
        mode3      = MODE_DIRECT;
        sel3       = 2'd0;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        #1;
        check("rst_in_ready4", 0, 32'(in_ready4), 32'h0);
        check("rst_in_ready3", 0, 32'(in_ready3), 32'h0);
        tick();
        tick();
        check("rst_in_ready4", 1, 32'(in_ready4), 32'h0);
        check("rst_out_valid4", 0, 32'(out_valid4), 32'h0);
        check("rst_out_data4", 0, 32'(out_data4), 32'h0);
        check("rst_out_src4", 0, 32'(out_src4), 32'h0);
        check("rst_out_valid3", 0, 32'(out_valid3), 32'h0);
        in_valid4 = 4'b0000;
        in_valid3 = 3'b000;
        reset     = 1'b0;

        for (int i = 0; i < 23; i++) begin
            mode4      = vecs[i].mode;
            sel4       = vecs[i].sel;
            in_valid4  = vecs[i].valid;
            out_ready4 = vecs[i].ordy;
            #1;
            check("in_ready", i, 32'(in_ready4), 32'(vecs[i].exp_rdy));
            tick();
            check("out_valid", i, 32'(out_valid4), 32'(vecs[i].exp_ov));
            check("out_data", i, 32'(out_data4), 32'(vecs[i].exp_od));
            check("out_src", i, 32'(out_src4), 32'(vecs[i].exp_src));
        end

        // N=3: load a word, then select the nonexistent source 3.
        in_valid3  = 3'b111;
        sel3       = 2'd0;
        out_ready3 = 1'b0;
        #1;
        check("n3_in_ready", 0, 32'(in_ready3), 32'b001);
        tick();
        check("n3_out_valid", 0, 32'(out_valid3), 32'h1);
        check("n3_out_data", 0, 32'(out_data3), 32'h0d2);
        sel3 = 2'd3;
        #1;
        check("n3_in_ready", 1, 32'(in_ready3), 32'h0);
        tick();
        check("n3_out_valid", 1, 32'(out_valid3), 32'h1);
        out_ready3 = 1'b1;
        #1;
        check("n3_in_ready", 2, 32'(in_ready3), 32'h0);
        tick();
        check("n3_out_valid", 2, 32'(out_valid3), 32'h0);
        check("n3_out_data", 2, 32'(out_data3), 32'h0d2);
        check("n3_out_src", 2, 32'(out_src3), 32'h0);
        in_valid3 = 3'b000;

        // Mid-transfer reset: first reach out_valid=1 with ptr=2.
        mode4      = MODE_RR;
        in_valid4  = 4'b0010;
        out_ready4 = 1'b1;
        #1;
        check("pre_rst_in_ready", 0, 32'(in_ready4), 32'b0010);
        tick();
        check("pre_rst_out_valid", 0, 32'(out_valid4), 32'h1);
        check("pre_rst_ptr", 0, 32'(dut4.ptr_q), 32'h2);
        reset     = 1'b1;
        in_valid4 = 4'b1111;
        #1;
        check("mid_rst_in_ready", 0, 32'(in_ready4), 32'h0);
        tick();
        check("mid_rst_out_valid", 0, 32'(out_valid4), 32'h0);
        check("mid_rst_out_data", 0, 32'(out_data4), 32'h0);
        check("mid_rst_out_src", 0, 32'(out_src4), 32'h0);
        check("mid_rst_ptr", 0, 32'(dut4.ptr_q), 32'h0);
        reset = 1'b0;
        #1;
        // ptr back at 0, so source 0 wins first.
        check("post_rst_in_ready", 0, 32'(in_ready4), 32'b0001);
        tick();
        check("post_rst_out_src", 0, 32'(out_src4), 32'h0);
        check("post_rst_out_data", 0, 32'(out_data4), 32'h011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
